// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide over
// WIDTH cycles, signed/unsigned modes, divide-by-zero and signed-overflow flags.
module muldiv_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             cf,
  output logic             vf,
  output logic             dz
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic               cf_q, cf_d, vf_q, vf_d, dz_q, dz_d;

  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     rem_sh_s;
  logic [WIDTH+1:0]   diff_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0]   q_fix_s, r_fix_s;
  logic [WIDTH-1:0]   fix_lo_s, fix_hi_s;
  logic               fix_cf_s, fix_vf_s, fix_dz_s;

  assign a_neg_s   = op_q[0] & a_q[WIDTH-1];
  assign b_neg_s   = op_q[0] & b_q[WIDTH-1];
  assign a_mag_s   = a_neg_s ? ((~a_q) + ONE_W) : a_q;
  assign b_mag_s   = b_neg_s ? ((~b_q) + ONE_W) : b_q;
  assign mul_sum_s = {1'b0, acc_q[WIDTH-1:0]} + (mq_q[0] ? {1'b0, opnd_q} : {1'b0, ZERO_W});
  assign rem_sh_s  = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
  // One extra bit beyond the shifted remainder so the top bit is a clean borrow.
  assign diff_s    = {1'b0, rem_sh_s} - {2'b00, opnd_q};
  assign prod_s    = {acc_q[WIDTH-1:0], mq_q};
  assign prod_fix_s = neg_lo_q ? ((~prod_s) + ONE_2W) : prod_s;
  assign q_fix_s   = neg_lo_q ? ((~mq_q) + ONE_W) : mq_q;
  assign r_fix_s   = neg_hi_q ? ((~acc_q[WIDTH-1:0]) + ONE_W) : acc_q[WIDTH-1:0];

  // Final result selection, sign correction and flag derivation used in FIX.
  always_comb begin
    fix_lo_s = ZERO_W;
    fix_hi_s = ZERO_W;
    fix_cf_s = 1'b0;
    fix_vf_s = 1'b0;
    fix_dz_s = 1'b0;
    if (op_q[1]) begin
      if (b_q == ZERO_W) begin
        fix_lo_s = ONES_W;
        fix_hi_s = a_q;
        fix_dz_s = 1'b1;
      end else if (op_q[0] && (a_q == MIN_W) && (b_q == ONES_W)) begin
        fix_lo_s = MIN_W;
        fix_hi_s = ZERO_W;
        fix_vf_s = 1'b1;
      end else begin
        fix_lo_s = q_fix_s;
        fix_hi_s = r_fix_s;
      end
    end else begin
      fix_lo_s = prod_fix_s[WIDTH-1:0];
      fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      if (op_q[0]) begin
        fix_cf_s = (prod_fix_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix_s[WIDTH-1]}});
        fix_vf_s = fix_cf_s;
      end else begin
        fix_cf_s = (prod_fix_s[2*WIDTH-1:WIDTH] != ZERO_W);
        fix_vf_s = 1'b0;
      end
    end
  end

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    mq_d     = mq_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cf_d     = cf_q;
    vf_d     = vf_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        opnd_d   = op_q[1] ? b_mag_s : a_mag_s;
        mq_d     = op_q[1] ? a_mag_s : b_mag_s;
        acc_d    = {(WIDTH+1){1'b0}};
        cnt_d    = {CNT_W{1'b0}};
        neg_lo_d = a_neg_s ^ b_neg_s;
        neg_hi_d = op_q[1] & a_neg_s;
        state_d  = S_ITER;
      end
      S_ITER: begin
        if (op_q[1]) begin
          if (!diff_s[WIDTH+1]) begin
            acc_d = diff_s[WIDTH:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh_s;
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {1'b0, mul_sum_s[WIDTH:1]};
          mq_d  = {mul_sum_s[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_ITER;
        end
      end
      S_FIX: begin
        lo_d    = fix_lo_s;
        hi_d    = fix_hi_s;
        cf_d    = fix_cf_s;
        vf_d    = fix_vf_s;
        dz_d    = fix_dz_s;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_ITER) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      a_q      <= ZERO_W;
      b_q      <= ZERO_W;
      opnd_q   <= ZERO_W;
      mq_q     <= ZERO_W;
      acc_q    <= {(WIDTH+1){1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lo_q     <= ZERO_W;
      hi_q     <= ZERO_W;
      cf_q     <= 1'b0;
      vf_q     <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      mq_q     <= mq_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cf_q     <= cf_d;
      vf_q     <= vf_d;
      dz_q     <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lo   = lo_q;
  assign hi   = hi_q;
  assign cf   = cf_q;
  assign vf   = vf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=8). Edge 1 is the edge that samples start;
// done is expected to be observed after edge 11.
module tb_muldiv_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, cf, vf, dz;
  logic [7:0] lo, hi;

  int tests = 0;
  int fails = 0;
  int lat;
  bit busy_ok;
  bit saw_done;

  muldiv_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .lo(lo), .hi(hi), .cf(cf), .vf(vf), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request; caller is positioned at a falling edge.
  task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
  endtask

  // Count rising edges until done is seen; optionally re-pulse start after edge 'repulse'.
  task automatic wait_done(input int repulse, output int edges, output bit bok);
    edges = 0;
    bok = 1'b1;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == repulse) begin
        start = 1'b1; op = 2'b10; a = 8'h01; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      if (!done && !busy) bok = 1'b0;
    end while (!done && edges < 30);
  endtask

  task automatic run(input string tag, input int repulse,
                     input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] elo, input logic [7:0] ehi,
                     input logic ecf, input logic evf, input logic edz);
    issue(o, x, y);
    wait_done(repulse, lat, busy_ok);
    check({tag, ".latency"}, 32'(lat), 32'd11);
    check({tag, ".busy_run"}, 32'(busy_ok), 32'd1);
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".lo"}, 32'(lo), 32'(elo));
    check({tag, ".hi"}, 32'(hi), 32'(ehi));
    check({tag, ".cf_vf_dz"}, 32'({cf, vf, dz}), 32'({ecf, evf, edz}));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset.ctrl", 32'({busy, done, cf, vf, dz}), 32'd0);
    check("reset.lohi", 32'({lo, hi}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run("mulu_200x3", 0, 2'b00, 8'hC8, 8'h03, 8'h58, 8'h02, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("hold_in_idle", 32'({lo, hi, cf}), 32'({8'h58, 8'h02, 1'b1}));

    @(negedge clk);
    run("mulu_ffxff", 0, 2'b00, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    run("muls_m3x5", 0, 2'b01, 8'hFD, 8'h05, 8'hF1, 8'hFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run("muls_80x80", 0, 2'b01, 8'h80, 8'h80, 8'h00, 8'h40, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    run("muls_7fxm1", 0, 2'b01, 8'h7F, 8'hFF, 8'h81, 8'hFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run("divu_100d7", 0, 2'b10, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run("divs_m7d2", 0, 2'b11, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run("divs_7dm2", 0, 2'b11, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run("divu_by0", 0, 2'b10, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    run("divs_by0", 0, 2'b11, 8'h80, 8'h00, 8'hFF, 8'h80, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    run("divs_ovf", 0, 2'b11, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);

    // start re-pulsed (sampled at edge 4) with a DIVU 1/1 that must be ignored
    @(negedge clk);
    run("repulse", 3, 2'b00, 8'hC8, 8'h03, 8'h58, 8'h02, 1'b1, 1'b0, 1'b0);

    // back-to-back: second request driven during the DONE cycle of the first
    @(negedge clk);
    run("b2b_first", 0, 2'b10, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0);
    run("b2b_second", 0, 2'b01, 8'hFD, 8'h05, 8'hF1, 8'hFF, 1'b0, 1'b0, 1'b0);

    // leave nonzero results, then reset mid-operation after edge 5
    @(negedge clk);
    run("pre_reset", 0, 2'b11, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    issue(2'b00, 8'hFF, 8'hFF);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_reset.ctrl", 32'({busy, done, cf, vf, dz}), 32'd0);
    check("async_reset.lohi", 32'({lo, hi}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("no_done_after_abort", 32'(saw_done), 32'd0);
    run("after_reset", 0, 2'b00, 8'hC8, 8'h03, 8'h58, 8'h02, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
